// File: rtl/nios_system_gpin_irq_ctrl_pkg.sv
// Shared constants for the GPIN interrupt controller: register map and
// the bit position of the fall-enable field inside the EDGE register.
package nios_system_gpin_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAPT = 2'd3;

  localparam int FALL_EN_LSB = 16;

  // Zero-extends a WIDTH-bit field (passed in the low bits) into a bus word.
  function automatic logic [WORD_W-1:0] field_word(input logic [15:0] field, input int width);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < width; i++) begin
      w[i] = field[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/nios_system_gpin_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the GPIN interrupt controller.
interface nios_system_gpin_irq_ctrl_if;

  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/nios_system_gpin_irq_ctrl_debounce.sv
// One input bit: two-flop synchroniser, stability counter, and one-cycle
// rise/fall pulses issued when a new level has been accepted.
module nios_system_gpin_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise, count consecutive disagreeing cycles, accept on the last one.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, matching real hardware.
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_meta <= din;
      sync_q    <= sync_meta;
      rise      <= 1'b0;
      fall      <= 1'b0;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q;
        cnt   <= '0;
        rise  <= ~level;
        fall  <= level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/nios_system_gpin_irq_ctrl.sv
// GPIN interrupt controller: debounced input port, per-bit rise/fall
// capture with write-1-to-clear, irq mask and a registered Avalon read mux.
module nios_system_gpin_irq_ctrl
  import nios_system_gpin_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  nios_system_gpin_irq_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_p;
  logic [WIDTH-1:0] fall_p;

  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] capt;

  logic             wr_edge;
  logic             wr_mask;
  logic [WIDTH-1:0] capt_clr;
  logic [WIDTH-1:0] capt_set;
  logic [WIDTH-1:0] capt_next;
  logic [31:0]      rd_mux;

  // The read strobe is not needed (readdata is always valid) and only some
  // writedata bits are stored; fold them here so they are visibly consumed.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.read, bus.writedata};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      nios_system_gpin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (in_port[gi]),
        .level (level[gi]),
        .rise  (rise_p[gi]),
        .fall  (fall_p[gi])
      );
    end
  endgenerate

  // Decode writes and compute the next capture vector; a new edge beats a clear.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    wr_edge   = 1'b0;
    wr_mask   = 1'b0;
    capt_clr  = '0;
    if (bus.write) begin
      wr_edge = (bus.address == ADDR_EDGE);
      wr_mask = (bus.address == ADDR_MASK);
      if (bus.address == ADDR_CAPT) begin
        capt_clr = bus.writedata[WIDTH-1:0];
      end
    end
    capt_set  = (rise_p & rise_en) | (fall_p & fall_en);
    capt_next = (capt & ~capt_clr) | capt_set;
  end

  // Read mux built from the current register contents (pre-write values).
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux = field_word(16'(level), WIDTH);
      ADDR_EDGE: rd_mux = field_word(16'(rise_en), WIDTH)
                        | (field_word(16'(fall_en), WIDTH) << FALL_EN_LSB);
      ADDR_MASK: rd_mux = field_word(16'(irq_mask), WIDTH);
      ADDR_CAPT: rd_mux = field_word(16'(capt), WIDTH);
      default:   rd_mux = '0;
    endcase
  end

  // Register file, sticky capture, registered read data and registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_en      <= '0;
      fall_en      <= '0;
      irq_mask     <= '0;
      capt         <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_edge) begin
        rise_en <= bus.writedata[WIDTH-1:0];
        fall_en <= bus.writedata[FALL_EN_LSB +: WIDTH];
      end
      if (wr_mask) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      capt         <= capt_next;
      bus.readdata <= rd_mux;
      irq          <= |(capt & irq_mask);
    end
  end

endmodule

// File: tb/tb_nios_system_gpin_irq_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// every cycle against a behavioural model of the register map.
module tb_nios_system_gpin_irq_ctrl;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_port;
  logic         irq;

  nios_system_gpin_irq_ctrl_if bus();

  nios_system_gpin_irq_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;

  // Model state: accepted levels, pending pulses, config, capture, outputs.
  logic [W-1:0] m_lvl, m_rise, m_fall, m_ren, m_fen, m_mask, m_capt;
  logic [31:0]  m_rd;
  logic         m_irq;
  int           run_len [W];
  logic [W-1:0] hist [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied right now.
  task automatic model_step();
    logic [W-1:0] sync, n_lvl, n_rise, n_fall, clr;
    logic [31:0]  word;
    if (reset) begin
      m_lvl = '0; m_rise = '0; m_fall = '0; m_ren = '0; m_fen = '0;
      m_mask = '0; m_capt = '0; m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < W; i++) run_len[i] = 0;
      hist.delete();
      return;
    end
    // The level seen by the debouncer is the input from two edges ago.
    sync = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    word = 32'h0;
    case (bus.address)
      2'd0: word = 32'(m_lvl);
      2'd1: word = 32'(m_ren) + (32'(m_fen) * 32'h1_0000);
      2'd2: word = 32'(m_mask);
      default: word = 32'(m_capt);
    endcase
    m_rd  = word;
    m_irq = (m_capt & m_mask) != 0;
    clr = (bus.write && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
    m_capt = (m_capt & ~clr) | (m_rise & m_ren) | (m_fall & m_fen);
    // A bit flips once it has disagreed for DB consecutive edges.
    n_lvl = m_lvl; n_rise = '0; n_fall = '0;
    for (int i = 0; i < W; i++) begin
      if (sync[i] != m_lvl[i]) begin
        run_len[i]++;
        if (run_len[i] == DB) begin
          run_len[i] = 0;
          n_lvl[i]   = sync[i];
          n_rise[i]  = sync[i];
          n_fall[i]  = ~sync[i];
        end
      end else begin
        run_len[i] = 0;
      end
    end
    m_lvl = n_lvl; m_rise = n_rise; m_fall = n_fall;
    if (bus.write && bus.address == 2'd1) begin
      m_ren = bus.writedata[W-1:0];
      m_fen = bus.writedata[16 +: W];
    end
    if (bus.write && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
    hist.push_back(in_port);
    if (hist.size() > 2) void'(hist.pop_front());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("readdata", bus.readdata, m_rd);
    check("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address   = a;
    bus.write     = 1'b1;
    bus.writedata = d;
    tick();
    bus.write     = 1'b0;
    bus.writedata = 32'h0;
  endtask

  initial begin
    reset = 1'b1; in_port = '0;
    bus.address = 2'd0; bus.read = 1'b1; bus.write = 1'b0; bus.writedata = 32'h0;
    @(negedge clk);
    ticks(2);
    reset = 1'b0;

    // Reset state: every register reads zero one cycle after its address.
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      tick();
      check("reset_read", bus.readdata, 32'h0);
      check("reset_irq", {31'b0, irq}, 32'h0);
    end

    // Held change is accepted after 2 sync + 4 stable cycles.
    bus.address = 2'd0;
    in_port = 8'h01;
    ticks(6);
    check("data_not_yet", bus.readdata, 32'h0);
    tick();
    check("data_held", bus.readdata, 32'h1);
    in_port = 8'h00;
    ticks(8);
    // A 3-cycle glitch never reaches the accepted level.
    in_port = 8'h01;
    ticks(3);
    in_port = 8'h00;
    ticks(8);
    check("data_glitch", bus.readdata, 32'h0);

    // Rising-edge capture on bit 0 with irq, then write-1 clear.
    wr(2'd1, 32'h0000_0001);
    wr(2'd2, 32'h0000_0001);
    bus.address = 2'd3;
    in_port = 8'h01;
    ticks(10);
    check("capt_rise", bus.readdata, 32'h1);
    check("irq_rise", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    check("capt_preclear", bus.readdata, 32'h1);
    tick();
    check("capt_cleared", bus.readdata, 32'h0);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // Fall-only capture on bit 1, masked, then unmask.
    wr(2'd1, 32'h0002_0000);
    wr(2'd2, 32'h0);
    bus.address = 2'd3;
    in_port = 8'h03;
    ticks(8);
    in_port = 8'h01;
    ticks(8);
    check("capt_fall", bus.readdata, 32'h2);
    check("irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h2);
    check("irq_unmask_same", {31'b0, irq}, 32'h0);
    tick();
    check("irq_unmask_next", {31'b0, irq}, 32'h1);

    // Capture of bit 2 coinciding with a write-1 clear of bit 2: set wins.
    wr(2'd3, 32'h2);
    wr(2'd1, 32'h0000_0004);
    bus.address = 2'd3;
    in_port = 8'h05;
    ticks(6);
    wr(2'd3, 32'h4);
    tick();
    check("capt_set_wins", bus.readdata, 32'h4);

    // Reset in the middle of a pending debounce discards it.
    wr(2'd3, 32'h4);
    wr(2'd2, 32'hff);
    wr(2'd1, 32'h00ff_00ff);
    bus.address = 2'd0;
    in_port = 8'h0d;
    ticks(4);
    reset = 1'b1;
    in_port = 8'h00;
    ticks(2);
    reset = 1'b0;
    ticks(8);
    check("rst_data", bus.readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    bus.address = 2'd3;
    ticks(2);
    check("rst_capt", bus.readdata, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      bus.address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        bus.write     = 1'b1;
        bus.writedata = $urandom;
      end
      tick();
      bus.write     = 1'b0;
      bus.writedata = 32'h0;
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
